// File: rtl/fifo_rd_stream_if.sv
// Registered VALID/READY word stream with end-of-transfer marker.
interface fifo_rd_stream_if #(
  parameter int unsigned C_WIDTH = 32
) ();
  logic [C_WIDTH-1:0] data;
  logic               valid;
  logic               last;
  logic               ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains LEN words from a 1-cycle-latency sync FIFO into a VALID/READY stream with LAST.
// A 3-entry prefetch buffer keeps 1 word/cycle without a READY-to-RD_EN combinational path.
module fifo_rd_stream #(
  parameter int unsigned C_WIDTH    = 32,
  parameter int unsigned C_LEN_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [C_LEN_BITS-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [C_WIDTH-1:0]    fifo_rd_data,
  input  logic                  fifo_empty,
  fifo_rd_stream_if.master      tx
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                state_q, state_d;
  logic [C_LEN_BITS-1:0] req_remain_q, req_remain_d;
  logic [C_LEN_BITS-1:0] tx_remain_q, tx_remain_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [C_WIDTH-1:0]    buf_q [3];
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic                  capture;
  logic                  pop;
  logic                  credit_ok;

  // Occupancy plus the word already requested must leave room in the buffer.
  assign credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
  assign fifo_rd_en = (state_q == StRun) & ~fifo_empty & (req_remain_q != '0) & credit_ok;

  assign capture  = inflight_q;
  assign tx.valid = (occ_q != 2'd0);
  assign tx.data  = buf_q[rd_ptr_q];
  assign tx.last  = tx.valid & (tx_remain_q == C_LEN_BITS'(1));
  assign pop      = tx.valid & tx.ready;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFin);

  always_comb begin
    state_d      = state_q;
    req_remain_d = req_remain_q;
    tx_remain_d  = tx_remain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            req_remain_d = len;
            tx_remain_d  = len;
            state_d      = StRun;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        if (fifo_rd_en && (req_remain_q != '0)) begin
          req_remain_d = req_remain_q - C_LEN_BITS'(1);
        end
        if (pop && (tx_remain_q != '0)) begin
          tx_remain_d = tx_remain_q - C_LEN_BITS'(1);
          if (tx_remain_q == C_LEN_BITS'(1)) begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (capture) begin
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    unique case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_remain_q <= '0;
      tx_remain_q  <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= 2'd0;
      wr_ptr_q     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_remain_q <= req_remain_d;
      tx_remain_q  <= tx_remain_d;
      occ_q        <= occ_d;
      inflight_q   <= fifo_rd_en;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      // Read data is valid the cycle after the request regardless of the current empty flag.
      if (capture) begin
        buf_q[wr_ptr_q] <= fifo_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural sync FIFO, expected-word scoreboard, stream monitor.
module tb_fifo_rd_stream;
  localparam int unsigned W  = 32;
  localparam int unsigned LB = 16;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LB-1:0] len = '0;
  logic          busy, done, fifo_rd_en, fifo_empty;
  logic [W-1:0]  fifo_rd_data;

  fifo_rd_stream_if #(.C_WIDTH(W)) tx_if ();

  fifo_rd_stream #(.C_WIDTH(W), .C_LEN_BITS(LB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .tx           (tx_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int rd_cnt   = 0;
  int hs_cnt   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] src_q[$];
  logic [W-1:0] fifo_q[$];

  assign fifo_empty = (push_cnt == pop_cnt);

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Sync FIFO model, 1-cycle read latency, flushed together with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      pop_cnt      <= push_cnt;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_rd_data <= fifo_q.pop_front();
      pop_cnt      <= pop_cnt + 1;
    end
  end

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      if (fifo_rd_en) rd_cnt++;
      if (fifo_empty) check("rd_while_empty", fifo_rd_en, 0);
      if (prev_stall) begin
        check("hold_valid", tx_if.valid, 1);
        check("hold_data", tx_if.data, prev_data);
        check("hold_last", tx_if.last, prev_last);
      end
      if (tx_if.valid && tx_if.ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", tx_if.valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_if.data, e.data);
          check("tx_last", tx_if.last, e.last);
        end
      end else if (tx_if.valid == 1'b0) begin
        if (tx_if.last) check("last_without_valid", tx_if.last, 0);
      end
      if (done) check("done_before_words", exp_q.size(), 0);
      prev_stall = tx_if.valid & ~tx_if.ready;
      prev_data  = tx_if.data;
      prev_last  = tx_if.last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_src(input logic [W-1:0] w);
    src_q.push_back(w);
  endtask

  task automatic push_fifo(input logic [W-1:0] w);
    fifo_q.push_back(w);
    push_cnt++;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    push_src(w);
    push_fifo(w);
  endtask

  // Expected words for a transfer are the next l words written into the FIFO.
  task automatic do_start(input int l);
    exp_t e;
    for (int i = 0; i < l; i++) begin
      e.data = src_q.pop_front();
      e.last = (i == l - 1);
      exp_q.push_back(e);
    end
    start = 1'b1;
    len   = LB'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_all_words"}, exp_q.size(), 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int   rd0;
    int   hs0;
    logic exp_rd, exp_v;

    tx_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", tx_if.valid, 0);
    check("rst_last", tx_if.last, 0);
    check("rst_data", tx_if.data, 0);
    rst_n = 1'b1;
    tick();

    // LEN=4, full-rate drain with cycle-exact timing.
    tx_if.ready = 1'b1;
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    push_word(32'hD);
    rd0 = rd_cnt;
    do_start(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_rd = (c <= 4);
      exp_v  = (c >= 3) && (c <= 6);
      check($sformatf("t1_rd_en_c%0d", c), fifo_rd_en, exp_rd);
      check($sformatf("t1_valid_c%0d", c), tx_if.valid, exp_v);
      check($sformatf("t1_last_c%0d", c), tx_if.last, (c == 6));
      check($sformatf("t1_done_c%0d", c), done, (c == 7));
      check($sformatf("t1_busy_c%0d", c), busy, (c <= 7));
      @(posedge clk);
      #1;
    end
    check("t1_rd_count", rd_cnt - rd0, 4);
    check("t1_all_words", exp_q.size(), 0);

    // LEN=3 with 6 words available: the surplus stays in the FIFO.
    for (int i = 1; i <= 6; i++) push_word(32'h2000_0000 + W'(i));
    rd0 = rd_cnt;
    do_start(3);
    wait_done("t2", 40);
    check("t2_rd_count", rd_cnt - rd0, 3);
    check("t2_fifo_left", push_cnt - pop_cnt, 3);

    // LEN=5 under back-pressure: only 3 prefetched, head word held.
    push_word(32'h3000_0001);
    push_word(32'h3000_0002);
    tx_if.ready = 1'b0;
    rd0 = rd_cnt;
    do_start(5);
    repeat (10) tick();
    check("t3_rd_stalled", rd_cnt - rd0, 3);
    check("t3_valid_held", tx_if.valid, 1);
    check("t3_head_data", tx_if.data, 32'h2000_0004);
    tx_if.ready = 1'b1;
    wait_done("t3", 40);
    check("t3_rd_count", rd_cnt - rd0, 5);

    // LEN=4 with words trickling in; empty toggles between arrivals.
    for (int i = 1; i <= 4; i++) push_src(32'h4000_0000 + W'(i));
    rd0 = rd_cnt;
    do_start(4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_empty_%0d", i), fifo_empty, 1);
      push_fifo(32'h4000_0000 + W'(i));
      repeat (3) tick();
    end
    wait_done("t4", 40);
    check("t4_rd_count", rd_cnt - rd0, 4);

    // LEN=0: immediate DONE, no reads; a START during FIN is dropped.
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    do_start(0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 1);
    start = 1'b1;
    len   = LB'(3);
    tick();
    start = 1'b0;
    check("t5_done_once", done, 0);
    check("t5_start_dropped", busy, 0);
    repeat (3) tick();
    check("t5_still_idle", busy, 0);
    check("t5_no_valid", tx_if.valid, 0);
    check("t5_no_reads", rd_cnt - rd0, 0);
    check("t5_no_words", hs_cnt - hs0, 0);

    // Asynchronous reset mid-transfer, then a clean LEN=2 transfer.
    for (int i = 1; i <= 6; i++) push_word(32'h6000_0000 + W'(i));
    hs0 = hs_cnt;
    do_start(6);
    for (int i = 0; i < 50; i++) begin
      if (hs_cnt - hs0 >= 2) break;
      tick();
    end
    check("t6_two_sent", hs_cnt - hs0, 2);
    tx_if.ready = 1'b0;
    repeat (3) tick();
    check("t6_pre_valid", tx_if.valid, 1);
    check("t6_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_rd_en", fifo_rd_en, 0);
    check("t6_rst_valid", tx_if.valid, 0);
    check("t6_rst_last", tx_if.last, 0);
    check("t6_rst_data", tx_if.data, 0);
    exp_q.delete();
    src_q.delete();
    tick();
    rst_n = 1'b1;
    tx_if.ready = 1'b1;
    tick();
    check("t6_flushed", fifo_empty, 1);
    push_word(32'h7000_0001);
    push_word(32'h7000_0002);
    rd0 = rd_cnt;
    do_start(2);
    wait_done("t6", 40);
    check("t6_rd_count", rd_cnt - rd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
